// File: rtl/egg_job_dispatcher.sv
// egg_job_dispatcher: accepts a mining job, sweeps its nonce range through
// egg_core one nonce at a time, and reports hashes below the target.
//
// Handshakes: job_* and found_* are valid/ready; a transfer happens on the
// rising clk edge where valid && ready are both high. The producer holds its
// payload stable while valid is high and ready is low. core_start/core_done
// are single-cycle pulses with exactly one nonce in flight.
module egg_job_dispatcher #(
  parameter int HDR_W        = 512,
  parameter int NONCE_W      = 32,
  parameter int HASH_W       = 256,
  parameter int TIMEOUT      = 1024,
  parameter bit STOP_ON_FIND = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [HDR_W-NONCE_W-1:0]  job_header,
  input  logic [HASH_W-1:0]         job_target,
  input  logic [NONCE_W-1:0]        job_nonce_start,
  input  logic [NONCE_W-1:0]        job_nonce_count,
  input  logic                      abort,
  output logic                      core_start,
  output logic [HDR_W-1:0]          core_header,
  input  logic                      core_done,
  input  logic [HASH_W-1:0]         core_hash,
  output logic                      found_valid,
  input  logic                      found_ready,
  output logic [NONCE_W-1:0]        found_nonce,
  output logic [HASH_W-1:0]         found_hash,
  output logic                      job_done,
  output logic                      timeout_err,
  output logic [NONCE_W-1:0]        hashes_tried
);

  localparam int TPL_W = HDR_W - NONCE_W;
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_REPORT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [TPL_W-1:0]   tpl_q, tpl_d;
  logic [HASH_W-1:0]  target_q, target_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] remaining_q, remaining_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [HASH_W-1:0]  hash_q, hash_d;
  logic [NONCE_W-1:0] tried_q, tried_d;
  logic [NONCE_W-1:0] tried_inc;
  logic               advance;
  logic               timeout_fire;

  // Attempt counter sticks at all-ones instead of wrapping.
  assign tried_inc = (&tried_q) ? tried_q : tried_q + NONCE_W'(1);

  // Next-state and datapath updates; abort outside IDLE overrides everything.
  always_comb begin
    state_d      = state_q;
    tpl_d        = tpl_q;
    target_d     = target_q;
    nonce_d      = nonce_q;
    remaining_d  = remaining_q;
    timer_d      = timer_q;
    hash_d       = hash_q;
    tried_d      = tried_q;
    advance      = 1'b0;
    timeout_fire = 1'b0;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (job_valid && !abort) begin
            tpl_d       = job_header;
            target_d    = job_target;
            nonce_d     = job_nonce_start;
            remaining_d = job_nonce_count;
            tried_d     = '0;
            state_d     = (job_nonce_count == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            hash_d  = core_hash;
            tried_d = tried_inc;
            state_d = S_CHECK;
          end else if (timer_q == TMR_LAST) begin
            timeout_fire = 1'b1;
            tried_d      = tried_inc;
            advance      = 1'b1;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        S_CHECK: begin
          if (hash_q < target_q) state_d = S_REPORT;
          else                   advance = 1'b1;
        end
        S_REPORT: begin
          if (found_ready) begin
            if (STOP_ON_FIND) state_d = S_DONE;
            else              advance = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      // Move to the next nonce, or finish when this was the last one.
      if (advance) begin
        if (remaining_q == NONCE_W'(1)) begin
          state_d = S_DONE;
        end else begin
          remaining_d = remaining_q - NONCE_W'(1);
          nonce_d     = nonce_q + NONCE_W'(1);
          state_d     = S_ISSUE;
        end
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tpl_q       <= '0;
      target_q    <= '0;
      nonce_q     <= '0;
      remaining_q <= '0;
      timer_q     <= '0;
      hash_q      <= '0;
      tried_q     <= '0;
    end else begin
      state_q     <= state_d;
      tpl_q       <= tpl_d;
      target_q    <= target_d;
      nonce_q     <= nonce_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      hash_q      <= hash_d;
      tried_q     <= tried_d;
    end
  end

  // Outputs decode the state; pulses and found_valid drop as soon as rst rises.
  always_comb begin
    job_ready    = (state_q == S_IDLE);
    core_start   = (state_q == S_ISSUE) && !rst;
    core_header  = {tpl_q, nonce_q};
    found_valid  = (state_q == S_REPORT) && !rst;
    found_nonce  = nonce_q;
    found_hash   = hash_q;
    job_done     = (state_q == S_DONE) && !rst;
    timeout_err  = timeout_fire && !rst;
    hashes_tried = tried_q;
  end

endmodule

// File: tb/tb_egg_job_dispatcher.sv
// Bench for egg_job_dispatcher: a behavioural egg_core responder, a monitor
// popping expected-value queues, and directed job scenarios.
module tb_egg_job_dispatcher;
  localparam int HDR_W   = 512;
  localparam int NONCE_W = 32;
  localparam int HASH_W  = 256;
  localparam int TIMEOUT = 8;
  localparam int TPL_W   = HDR_W - NONCE_W;
  localparam logic [HASH_W-1:0] HIT_HASH = 256'h5;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance (continue sweep after a find)
  logic job_valid, job_ready, abort, core_start, core_done;
  logic found_valid, found_ready, job_done, timeout_err;
  logic [TPL_W-1:0]   job_header;
  logic [HASH_W-1:0]  job_target, core_hash, found_hash;
  logic [NONCE_W-1:0] job_nonce_start, job_nonce_count, found_nonce, hashes_tried;
  logic [HDR_W-1:0]   core_header;

  // stop-on-find instance
  logic s_job_valid, s_job_ready, s_abort, s_core_start, s_core_done;
  logic s_found_valid, s_found_ready, s_job_done, s_timeout_err;
  logic [TPL_W-1:0]   s_job_header;
  logic [HASH_W-1:0]  s_job_target, s_core_hash, s_found_hash;
  logic [NONCE_W-1:0] s_job_nonce_start, s_job_nonce_count, s_found_nonce, s_hashes_tried;
  logic [HDR_W-1:0]   s_core_header;

  egg_job_dispatcher #(.HDR_W(HDR_W), .NONCE_W(NONCE_W), .HASH_W(HASH_W),
                       .TIMEOUT(TIMEOUT), .STOP_ON_FIND(1'b0)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_header(job_header), .job_target(job_target),
    .job_nonce_start(job_nonce_start), .job_nonce_count(job_nonce_count),
    .abort(abort), .core_start(core_start), .core_header(core_header),
    .core_done(core_done), .core_hash(core_hash), .found_valid(found_valid),
    .found_ready(found_ready), .found_nonce(found_nonce), .found_hash(found_hash),
    .job_done(job_done), .timeout_err(timeout_err), .hashes_tried(hashes_tried)
  );

  egg_job_dispatcher #(.HDR_W(HDR_W), .NONCE_W(NONCE_W), .HASH_W(HASH_W),
                       .TIMEOUT(TIMEOUT), .STOP_ON_FIND(1'b1)) dut_s (
    .clk(clk), .rst(rst), .job_valid(s_job_valid), .job_ready(s_job_ready),
    .job_header(s_job_header), .job_target(s_job_target),
    .job_nonce_start(s_job_nonce_start), .job_nonce_count(s_job_nonce_count),
    .abort(s_abort), .core_start(s_core_start), .core_header(s_core_header),
    .core_done(s_core_done), .core_hash(s_core_hash), .found_valid(s_found_valid),
    .found_ready(s_found_ready), .found_nonce(s_found_nonce), .found_hash(s_found_hash),
    .job_done(s_job_done), .timeout_err(s_timeout_err), .hashes_tried(s_hashes_tried)
  );

  // scoreboard
  logic [HDR_W-1:0]          exp_start_q[$];
  logic [HDR_W-1:0]          exp_to_q[$];
  logic [NONCE_W+HASH_W-1:0] exp_found_q[$];
  logic [NONCE_W-1:0]        exp_done_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [HDR_W-1:0] act,
                       input logic [HDR_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic note_fail(input string name, input logic [HDR_W-1:0] act);
    n_checks++;
    $display("FAIL %s: got %0h expected no such event", name, act);
  endtask

  // egg_core model controls
  logic               hit_en = 1'b0, drop_en = 1'b0;
  logic [NONCE_W-1:0] hit_nonce = '0, drop_nonce = '0;
  int stray_req = 0;
  int stray_ack = 0;
  int s_start_cnt = 0;

  always @(negedge clk) if (!rst && s_core_start) s_start_cnt <= s_start_cnt + 1;

  // egg_core model: answers each core_start 4 cycles later unless dropped
  initial begin : core_model
    logic [NONCE_W-1:0] n;
    core_done = 1'b0;
    core_hash = '0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_ack) begin
        @(posedge clk); #1 core_done = 1'b1; core_hash = '0;
        @(posedge clk); #1 core_done = 1'b0;
        stray_ack++;
      end else if (core_start && !rst) begin
        n = core_header[NONCE_W-1:0];
        if (!(drop_en && n == drop_nonce)) begin
          repeat (4) @(posedge clk);
          #1 core_done = 1'b1;
          core_hash = (hit_en && n == hit_nonce) ? HIT_HASH : '1;
          @(posedge clk); #1 core_done = 1'b0;
        end
      end
    end
  end

  // monitor: pops an expectation whenever the DUT presents an event
  initial begin : monitor
    logic prev_fv, prev_hs, prev_ab;
    logic [NONCE_W-1:0] prev_fn;
    logic [HASH_W-1:0]  prev_fh;
    prev_fv = 1'b0; prev_hs = 1'b0; prev_ab = 1'b0; prev_fn = '0; prev_fh = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (core_start) begin
          if (exp_start_q.size() == 0) note_fail("core_start_extra", core_header);
          else check("core_header", core_header, exp_start_q.pop_front());
        end
        if (timeout_err) begin
          if (exp_to_q.size() == 0) note_fail("timeout_err_extra", core_header);
          else check("timeout_header", core_header, exp_to_q.pop_front());
        end
        if (found_valid && found_ready) begin
          if (exp_found_q.size() == 0) note_fail("found_extra", {found_nonce, found_hash});
          else check("found_result", {found_nonce, found_hash}, exp_found_q.pop_front());
        end
        if (job_done) begin
          if (exp_done_q.size() == 0) note_fail("job_done_extra", hashes_tried);
          else check("done_hashes_tried", hashes_tried, exp_done_q.pop_front());
        end
        if (prev_fv && !prev_hs && !prev_ab) begin
          check("found_valid_hold", found_valid, 1);
          check("found_nonce_stable", found_nonce, prev_fn);
          check("found_hash_stable", found_hash, prev_fh);
        end
      end
      prev_fv = found_valid;
      prev_hs = found_valid && found_ready;
      prev_ab = abort;
      prev_fn = found_nonce;
      prev_fh = found_hash;
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic send_job(input logic [TPL_W-1:0] tpl, input logic [HASH_W-1:0] tgt,
                          input logic [NONCE_W-1:0] st, input logic [NONCE_W-1:0] cnt);
    int n;
    n = 0;
    while (!job_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!job_ready) note_fail("job_ready_wait", {31'd0, job_ready});
    job_valid = 1'b1; job_header = tpl; job_target = tgt;
    job_nonce_start = st; job_nonce_count = cnt;
    @(posedge clk); #1 job_valid = 1'b0;
  endtask

  task automatic wait_job_done(input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!job_done && n < budget);
    if (!job_done) note_fail("job_done_wait", {31'd0, job_done});
    @(posedge clk); #1;
  endtask

  task automatic wait_found(input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!found_valid && n < budget);
    if (!found_valid) note_fail("found_valid_wait", {31'd0, found_valid});
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [TPL_W-1:0] hdr_a, hdr_b;
    int n, seen;
    hdr_a = {15{32'hCAFE_0001}};
    hdr_b = {15{32'h1234_5678}};
    rst = 1'b1; abort = 1'b0; job_valid = 1'b0; found_ready = 1'b1;
    job_header = '0; job_target = '0; job_nonce_start = '0; job_nonce_count = '0;
    s_job_valid = 1'b0; s_abort = 1'b0; s_found_ready = 1'b1; s_core_done = 1'b0;
    s_core_hash = '0; s_job_header = '0; s_job_target = '0;
    s_job_nonce_start = '0; s_job_nonce_count = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_job_ready", job_ready, 1);
    check("rst_core_start", core_start, 0);
    check("rst_found_valid", found_valid, 0);
    check("rst_job_done", job_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_hashes_tried", hashes_tried, 0);
    check("rst_core_header", core_header, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_job_ready", job_ready, 1);
    @(posedge clk); #1;

    // basic miss sweep with latency checks
    for (int i = 0; i < 3; i++) exp_start_q.push_back({hdr_a, NONCE_W'(32'h10 + i)});
    exp_done_q.push_back(32'd3);
    send_job(hdr_a, '0, 32'h10, 32'd3);
    @(negedge clk);
    check("accept_to_core_start", core_start, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!core_done && n < 20);
    check("core_done_seen", core_done, 1);
    @(negedge clk);
    check("check_cycle_no_start", core_start, 0);
    @(negedge clk);
    check("miss_to_next_start", core_start, 1);
    wait_job_done(200);
    check("miss_hashes_tried", hashes_tried, 3);

    // hit with backpressure, sweep continues
    hit_en = 1'b1; hit_nonce = 32'h102; found_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_start_q.push_back({hdr_b, NONCE_W'(32'h100 + i)});
    exp_found_q.push_back({NONCE_W'(32'h102), HIT_HASH});
    exp_done_q.push_back(32'd4);
    send_job(hdr_b, 256'h10, 32'h100, 32'd4);
    wait_found(100);
    check("hit_found_nonce", found_nonce, 32'h102);
    check("hit_found_hash", found_hash, HIT_HASH);
    repeat (5) begin
      @(negedge clk);
      check("found_valid_backpressure", found_valid, 1);
    end
    @(posedge clk); #1 found_ready = 1'b1;
    wait_job_done(200);
    check("hit_hashes_tried", hashes_tried, 4);

    // hash equal to target is not a hit
    exp_start_q.push_back({hdr_a, NONCE_W'(32'h102)});
    exp_done_q.push_back(32'd1);
    send_job(hdr_a, HIT_HASH, 32'h102, 32'd1);
    wait_job_done(100);
    hit_en = 1'b0;

    // nonce wrap, then zero count
    exp_start_q.push_back({hdr_b, NONCE_W'(32'hFFFF_FFFF)});
    exp_start_q.push_back({hdr_b, NONCE_W'(32'h0)});
    exp_done_q.push_back(32'd2);
    send_job(hdr_b, '0, 32'hFFFF_FFFF, 32'd2);
    wait_job_done(100);
    check("wrap_hashes_tried", hashes_tried, 2);
    exp_done_q.push_back(32'd0);
    send_job(hdr_b, '0, 32'h55, 32'd0);
    @(negedge clk);
    check("zero_count_done_latency", job_done, 1);
    check("zero_count_no_start", core_start, 0);
    @(posedge clk); #1;

    // timeout on second nonce, then a stray core_done in IDLE
    drop_en = 1'b1; drop_nonce = 32'h201;
    for (int i = 0; i < 3; i++) exp_start_q.push_back({hdr_a, NONCE_W'(32'h200 + i)});
    exp_to_q.push_back({hdr_a, NONCE_W'(32'h201)});
    exp_done_q.push_back(32'd3);
    send_job(hdr_a, '0, 32'h200, 32'd3);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(core_start && core_header[NONCE_W-1:0] == 32'h201) && n < 50);
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout_err && n < 20);
    check("timeout_latency", n, TIMEOUT);
    wait_job_done(100);
    drop_en = 1'b0;
    check("timeout_hashes_tried", hashes_tried, 3);
    stray_req++;
    n = 0;
    while (stray_ack != stray_req && n < 20) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    check("stray_done_ignored", hashes_tried, 3);
    check("stray_job_ready", job_ready, 1);
    @(posedge clk); #1;

    // abort during WAIT; the late core_done must be ignored
    exp_start_q.push_back({hdr_b, NONCE_W'(32'h300)});
    send_job(hdr_b, '1, 32'h300, 32'd5);
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_job_ready", job_ready, 1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (job_done || found_valid || core_start) seen++;
    end
    check("abort_quiet", seen, 0);
    check("abort_hashes_tried", hashes_tried, 0);
    @(posedge clk); #1;

    // abort beats job_valid in IDLE
    abort = 1'b1; job_valid = 1'b1; job_header = hdr_a; job_target = '0;
    job_nonce_start = 32'h500; job_nonce_count = 32'd1;
    @(posedge clk); #1 abort = 1'b0; job_valid = 1'b0;
    @(negedge clk);
    check("abort_priority_no_start", core_start, 0);
    check("abort_priority_idle", job_ready, 1);
    @(posedge clk); #1;

    // reset during REPORT
    hit_en = 1'b1; hit_nonce = 32'h400; found_ready = 1'b0;
    exp_start_q.push_back({hdr_a, NONCE_W'(32'h400)});
    send_job(hdr_a, 256'h10, 32'h400, 32'd2);
    wait_found(100);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_drops_found_valid", found_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst2_job_ready", job_ready, 1);
    check("rst2_found_valid", found_valid, 0);
    check("rst2_job_done", job_done, 0);
    check("rst2_hashes_tried", hashes_tried, 0);
    check("rst2_core_header", core_header, 0);
    check("rst2_found_nonce", found_nonce, 0);
    check("rst2_found_hash", found_hash, 0);
    @(posedge clk); #1 rst = 1'b0; found_ready = 1'b1; hit_en = 1'b0;
    @(posedge clk); #1;

    // STOP_ON_FIND instance: hit on first nonce ends the job
    check("s_job_ready_idle", s_job_ready, 1);
    s_job_valid = 1'b1; s_job_header = hdr_b; s_job_target = 256'h10;
    s_job_nonce_start = 32'h700; s_job_nonce_count = 32'd3;
    @(posedge clk); #1 s_job_valid = 1'b0;
    @(negedge clk);
    check("s_core_start", s_core_start, 1);
    check("s_core_header", s_core_header, {hdr_b, NONCE_W'(32'h700)});
    @(posedge clk); #1;
    @(posedge clk); #1 s_core_done = 1'b1; s_core_hash = 256'h1;
    @(posedge clk); #1 s_core_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("s_found_valid", s_found_valid, 1);
    check("s_found_nonce", s_found_nonce, 32'h700);
    check("s_found_hash", s_found_hash, 256'h1);
    @(negedge clk);
    check("s_job_done_after_handshake", s_job_done, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    check("s_single_core_start", s_start_cnt, 1);
    check("s_next_job_ready", s_job_ready, 1);
    s_job_valid = 1'b1; s_job_nonce_count = 32'd0;
    @(posedge clk); #1 s_job_valid = 1'b0;
    @(negedge clk);
    check("s_next_job_accepted", s_job_done, 1);
    @(posedge clk); #1;

    // final report
    repeat (4) @(posedge clk);
    check("exp_start_left", exp_start_q.size(), 0);
    check("exp_timeout_left", exp_to_q.size(), 0);
    check("exp_found_left", exp_found_q.size(), 0);
    check("exp_done_left", exp_done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/egg_job_dispatcher.md
Name: egg_job_dispatcher

Overview:
- Initiator side of the egg_core mining handshake. It accepts a mining job (header template, target, nonce range) and sweeps nonces through egg_core one at a time.
- Each returned gold_hash is compared against the target; winning nonces are reported on a valid/ready result port.
- Sits between the hare_compute/chest job source and egg_core. It replaces the static header tie-off with a sequenced work feed.

Parameters:
- HDR_W, 512, full header width presented to egg_core; nonce occupies bits [NONCE_W-1:0].
- NONCE_W, 32, nonce and counter width.
- HASH_W, 256, hash/target width.
- TIMEOUT, 1024, cycles in WAIT without core_done before the nonce is abandoned; must be ≥2.
- STOP_ON_FIND, 0, 1 = end the job after the first accepted result; 0 = continue the sweep.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  dispatcher can accept a job (high only in IDLE)
- job_header  in  HDR_W-NONCE_W  header template, upper bits
- job_target  in  HASH_W  hit when hash < target (unsigned, strict)
- job_nonce_start  in  NONCE_W  first nonce
- job_nonce_count  in  NONCE_W  number of nonces to try
- abort  in  1  cancel the current job
- core_start  out  1  one-cycle pulse launching egg_core
- core_header  out  HDR_W  {header template, current nonce}; stable from core_start until leaving WAIT
- core_done  in  1  egg_core completion pulse
- core_hash  in  HASH_W  egg_core gold_hash, valid with core_done
- found_valid  out  1  result available
- found_ready  in  1  result consumer ready
- found_nonce  out  NONCE_W  winning nonce
- found_hash  out  HASH_W  winning hash
- job_done  out  1  one-cycle pulse at job end
- timeout_err  out  1  one-cycle pulse when a nonce times out
- hashes_tried  out  NONCE_W  completed attempts this job (done or timeout), saturating at all-ones

Behaviour:
- Reset: state IDLE. All outputs 0 except job_ready=1. All registers (including nonce and remaining) 0.
- Reset asserted in any state forces IDLE next cycle and drops found_valid/core_start immediately.
- States: IDLE, ISSUE, WAIT, CHECK, REPORT, DONE.
- IDLE: job_ready=1. On job_valid, latch header/target/start/count, set nonce=start, remaining=count, clear hashes_tried.
  - Next state is DONE if count==0, else ISSUE.
- ISSUE: core_start=1 for exactly one cycle, core_header={template,nonce}, wait timer cleared. Next state WAIT.
- WAIT:
  - core_done → latch core_hash, increment hashes_tried, go to CHECK.
  - Otherwise the timer increments; when it reaches TIMEOUT-1: timeout_err pulse, increment hashes_tried, ADVANCE.
  - core_done and timeout in the same cycle: done wins, no timeout_err.
- CHECK: if latched hash < target, go to REPORT; otherwise ADVANCE.
- REPORT: found_valid=1, found_nonce/found_hash held stable until found_valid && found_ready. Then:
  - STOP_ON_FIND=1 → DONE.
  - STOP_ON_FIND=0 → ADVANCE.
- ADVANCE (transition action, not a state):
  - remaining==1 → DONE.
  - Otherwise remaining-=1 and nonce+=1 modulo 2^NONCE_W (0xFFFFFFFF wraps to 0, no error), then ISSUE.
- DONE: job_done=1 for one cycle, then IDLE.
- core_done outside WAIT is ignored; hash is not latched and the counter does not change.
- abort (any non-IDLE state): next state IDLE with no job_done pulse.
  - found_valid drops the cycle after abort.
  - A core_done arriving later is ignored.
  - abort in IDLE has no effect; abort has priority over job_valid in the same cycle.
- Latency:
  - Job accepted at cycle T → core_start at T+1.
  - core_done at cycle D → CHECK at D+1; miss → next core_start at D+2; hit → found_valid at D+2.
  - Last-nonce miss → job_done at D+2.
- Throughput: one nonce in flight at a time; hashes_tried counts every nonce resolved by done or timeout.

Test Plan:
- Basic miss sweep: start=0x10, count=3, target=0, core_done 4 cycles after each start → core_start nonces 0x10,0x11,0x12; no found_valid; job_done once; hashes_tried=3.
- Hit with backpressure: count=4, core returns hash 0x…05 for nonce 2 only, target=0x…10, found_ready low for 5 cycles → found_valid held with found_nonce=start+2 and stable hash; sweep continues to job_done; hashes_tried=4.
- STOP_ON_FIND=1, hit on first nonce, found_ready=1 → exactly one core_start, job_done 1 cycle after handshake; next job_valid accepted.
- Wrap and zero count: start=0xFFFFFFFF, count=2 → nonces 0xFFFFFFFF then 0x00000000. Then count=0 → job_done at T+1, no core_start.
- Timeout: TIMEOUT=8, core_done never asserted for the 2nd nonce → timeout_err pulse 8 cycles into WAIT, next nonce issued; stray late core_done ignored.
- Abort/reset mid-job: abort during WAIT, then core_done → IDLE, job_ready=1, no job_done, no found_valid. rst during REPORT → found_valid=0 next cycle, all outputs at reset values.
